// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - execute/memory/writeback handshake and data-response bundle for mem_stage
interface mem_stage_if;
    logic        es_to_ms_valid;
    logic [71:0] es_to_ms_bus;
    logic        ms_allowin;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [38:0] ms_fwd_bus;

    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, data_sram_data_ok, data_sram_rdata, ws_allowin,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
    );

    modport master (
        output es_to_ms_valid, es_to_ms_bus, data_sram_data_ok, data_sram_rdata, ws_allowin,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - single-entry memory pipeline stage waiting on data SRAM responses
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  ms_if
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HELD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_ms_valid;
    logic [71:0] r_bus;
    logic [31:0] r_rdata_buf;

    logic        w_store_op;
    logic        w_load_op;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_alu_result;
    logic [31:0] w_pc;
    logic        w_mem_op;
    logic        w_in_mem_op;
    logic        w_ready_go;
    logic        w_allowin;
    logic        w_capture;
    logic        w_fwd_pending;
    logic [31:0] w_final_result;

    assign w_store_op   = r_bus[71];
    assign w_load_op    = r_bus[70];
    assign w_gr_we      = r_bus[69];
    assign w_dest       = r_bus[68:64];
    assign w_alu_result = r_bus[63:32];
    assign w_pc         = r_bus[31:0];
    assign w_mem_op     = w_load_op | w_store_op;
    assign w_in_mem_op  = ms_if.es_to_ms_bus[71] | ms_if.es_to_ms_bus[70];

    // Response arrives but writeback is stalled: park it so it cannot be lost.
    assign w_capture = (r_state == S_WAIT) && ms_if.data_sram_data_ok && !ms_if.ws_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_allowin) begin
            w_state_nxt = (ms_if.es_to_ms_valid && w_in_mem_op) ? S_WAIT : S_IDLE;
        end else if (w_capture) begin
            w_state_nxt = S_HELD;
        end
    end

    always_comb begin
        w_ready_go = !w_mem_op
                   || ((r_state == S_WAIT) && ms_if.data_sram_data_ok)
                   || (r_state == S_HELD);
        w_allowin  = !r_ms_valid || (w_ready_go && ms_if.ws_allowin);
        if (w_load_op) begin
            w_final_result = (r_state == S_HELD) ? r_rdata_buf : ms_if.data_sram_rdata;
        end else begin
            w_final_result = w_alu_result;
        end
        w_fwd_pending = r_ms_valid && w_load_op && !w_ready_go;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ms_valid  <= 1'b0;
            r_bus       <= 72'd0;
            r_rdata_buf <= 32'd0;
        end else begin
            if (w_allowin) begin
                r_ms_valid <= ms_if.es_to_ms_valid;
                r_bus      <= ms_if.es_to_ms_bus;
            end
            if (w_capture) begin
                r_rdata_buf <= ms_if.data_sram_rdata;
            end
        end
    end

    assign ms_if.ms_allowin     = w_allowin;
    assign ms_if.ms_to_ws_valid = r_ms_valid && w_ready_go;
    assign ms_if.ms_to_ws_bus   = {w_gr_we, w_dest, w_final_result, w_pc};
    assign ms_if.ms_fwd_bus     = {r_ms_valid && w_gr_we, w_fwd_pending, w_dest, w_final_result};
endmodule
